// File: rtl/alu_wide_sequencer.sv
// -----------------------------------------------------------------------------
// alu_wide_sequencer
//
// Multi-cycle client of a 16-bit combinational ALU. One request is accepted
// per valid/ready handshake. Narrow requests take a single ALU pass. Wide
// (32-bit) requests take two chained passes, low half then high half.
// Carry/borrow is chained through alu_cin/alu_cout, and the shift bits that
// cross the half boundary are patched here.
//
// FSM: IDLE -> LO -> (HI if wide) -> DONE -> IDLE
//
// Ports
//   clk, reset_n             clock; asynchronous active-low reset
//   req_valid/req_ready      request handshake (ready only in IDLE)
//   req_op[3:0]              `OP_* opcode
//   req_wide                 1 = 32-bit operation, 0 = 16-bit
//   req_a/req_b[31:0]        operands
//   req_cin                  carry/borrow into the low half (ADD/SUB)
//   alu_a/alu_b/alu_op/alu_cin   drive the ALU (all 0 in IDLE and DONE)
//   alu_c[15:0], alu_cout    ALU result and carry/borrow out
//   rsp_valid/rsp_ready      response handshake
//   rsp_c[31:0], rsp_cout    result (upper half 0 for narrow), final carry
//
// Optional feature, macro ALU_SEQ_FLAGS_EN:
//   rsp_zero                 result word is zero (32 bits wide, 16 narrow)
//   rsp_ovf                  signed overflow of ADD/SUB from the top half
// -----------------------------------------------------------------------------

`ifndef OP_ID
`define OP_ID   4'h0
`define OP_NAND 4'h1
`define OP_NOR  4'h2
`define OP_XNOR 4'h3
`define OP_NOT  4'h4
`define OP_AND  4'h5
`define OP_OR   4'h6
`define OP_XOR  4'h7
`define OP_ADD  4'h8
`define OP_SUB  4'h9
`define OP_RR   4'hA
`define OP_ARS  4'hB
`define OP_LRS  4'hC
`define OP_RL   4'hD
`define OP_ALS  4'hE
`define OP_LHI  4'hF
`endif

module alu_wide_sequencer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic        req_wide,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        req_cin,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic        alu_cin,
    output logic [3:0]  alu_op,
    input  logic [15:0] alu_c,
    input  logic        alu_cout,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_c,
    output logic        rsp_cout
`ifdef ALU_SEQ_FLAGS_EN
    ,
    output logic        rsp_zero,
    output logic        rsp_ovf
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LO,
        ST_HI,
        ST_DONE
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    // Request captured at accept; the request inputs are not looked at again.
    logic [3:0]  r_op;
    logic        r_wide;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        r_cin;

    // Low-half result of a wide operation, already boundary-patched.
    logic [15:0] r_lo_c;
    logic        r_lo_cout;

    logic [31:0] r_rsp_c;
    logic        r_rsp_cout;

    logic        w_is_arith;
    logic        w_is_rshift;
    logic        w_is_lshift;
    logic [3:0]  w_lo_op;
    logic [15:0] w_lo_fix;
    logic [15:0] w_hi_fix;
    logic [31:0] w_res;
    logic        w_res_cout;
    logic        w_load_rsp;

    assign w_is_arith  = (r_op == `OP_ADD) || (r_op == `OP_SUB);
    assign w_is_rshift = (r_op == `OP_RR) || (r_op == `OP_ARS) || (r_op == `OP_LRS);
    assign w_is_lshift = (r_op == `OP_RL) || (r_op == `OP_ALS);

    // A wide shift's low half is always a plain shift; the bit that should
    // come from the other half is substituted afterwards.
    always_comb begin : lo_op_sel
        w_lo_op = r_op;
        if (r_wide && w_is_rshift) begin
            w_lo_op = `OP_LRS;
        end else if (r_wide && w_is_lshift) begin
            w_lo_op = `OP_ALS;
        end
    end

    always_comb begin : fsm_comb
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        alu_a       = 16'h0000;
        alu_b       = 16'h0000;
        alu_cin     = 1'b0;
        alu_op      = 4'h0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_nxt = ST_LO;
                end
            end
            ST_LO: begin
                alu_a       = r_a[15:0];
                alu_b       = r_b[15:0];
                alu_cin     = w_is_arith & r_cin;
                alu_op      = w_lo_op;
                w_state_nxt = r_wide ? ST_HI : ST_DONE;
            end
            ST_HI: begin
                alu_a       = r_a[31:16];
                alu_b       = r_b[31:16];
                alu_cin     = w_is_arith & r_lo_cout;
                alu_op      = w_is_lshift ? `OP_ALS : r_op;
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Boundary bits for wide shifts. The HI patch only matters in ST_HI,
    // which is reached for wide requests alone.
    always_comb begin : boundary_fix
        w_lo_fix = alu_c;
        w_hi_fix = alu_c;
        if (r_wide && w_is_rshift) begin
            w_lo_fix[15] = r_a[16];
        end
        if (r_wide && w_is_lshift) begin
            w_lo_fix[0] = (r_op == `OP_RL) ? r_a[31] : 1'b0;
        end
        if (r_op == `OP_RR) begin
            w_hi_fix[15] = r_a[0];
        end
        if (w_is_lshift) begin
            w_hi_fix[0] = r_a[15];
        end
    end

    assign w_res      = (r_state == ST_HI) ? {w_hi_fix, r_lo_c} : {16'h0000, alu_c};
    assign w_res_cout = w_is_arith & alu_cout;
    assign w_load_rsp = (r_state == ST_HI) || ((r_state == ST_LO) && !r_wide);

    always_ff @(posedge clk or negedge reset_n) begin : fsm_state
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register sees pre-edge values, regardless of statement order.
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin : datapath
        if (!reset_n) begin
            r_op       <= 4'h0;
            r_wide     <= 1'b0;
            r_a        <= 32'h0;
            r_b        <= 32'h0;
            r_cin      <= 1'b0;
            r_lo_c     <= 16'h0000;
            r_lo_cout  <= 1'b0;
            r_rsp_c    <= 32'h0;
            r_rsp_cout <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) && req_valid) begin
                r_op   <= req_op;
                // LHI only builds a 16-bit constant, so it always runs narrow.
                r_wide <= req_wide && (req_op != `OP_LHI);
                r_a    <= req_a;
                r_b    <= req_b;
                r_cin  <= req_cin;
            end
            if ((r_state == ST_LO) && r_wide) begin
                r_lo_c    <= w_lo_fix;
                r_lo_cout <= alu_cout;
            end
            if (w_load_rsp) begin
                r_rsp_c    <= w_res;
                r_rsp_cout <= w_res_cout;
            end
        end
    end

    assign rsp_c    = r_rsp_c;
    assign rsp_cout = r_rsp_cout;

`ifdef ALU_SEQ_FLAGS_EN
    logic r_rsp_zero;
    logic r_rsp_ovf;
    logic w_sa;
    logic w_sb;
    logic w_sr;
    logic w_ovf;

    // Sign bits of the most significant half being computed right now.
    assign w_sa = (r_state == ST_HI) ? r_a[31] : r_a[15];
    assign w_sb = (r_state == ST_HI) ? r_b[31] : r_b[15];
    assign w_sr = alu_c[15];

    always_comb begin : ovf_calc
        w_ovf = 1'b0;
        if (r_op == `OP_ADD) begin
            w_ovf = (w_sa == w_sb) && (w_sr != w_sa);
        end else if (r_op == `OP_SUB) begin
            w_ovf = (w_sa != w_sb) && (w_sr != w_sa);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin : flags
        if (!reset_n) begin
            r_rsp_zero <= 1'b0;
            r_rsp_ovf  <= 1'b0;
        end else if (w_load_rsp) begin
            // Narrow results have a zero upper half, so one compare serves both.
            r_rsp_zero <= (w_res == 32'h0);
            r_rsp_ovf  <= w_ovf;
        end
    end

    assign rsp_zero = r_rsp_zero;
    assign rsp_ovf  = r_rsp_ovf;
`endif

endmodule

// File: tb/tb_alu_wide_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for alu_wide_sequencer. Provides a behavioural 16-bit ALU on the
// alu_* ports, applies a table of directed vectors, hand-written corner
// sequences (HI carry, backpressure, reset mid-operation) and randomized
// requests checked against a 32-bit arithmetic reference model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

`ifndef OP_ID
`define OP_ID   4'h0
`define OP_NAND 4'h1
`define OP_NOR  4'h2
`define OP_XNOR 4'h3
`define OP_NOT  4'h4
`define OP_AND  4'h5
`define OP_OR   4'h6
`define OP_XOR  4'h7
`define OP_ADD  4'h8
`define OP_SUB  4'h9
`define OP_RR   4'hA
`define OP_ARS  4'hB
`define OP_LRS  4'hC
`define OP_RL   4'hD
`define OP_ALS  4'hE
`define OP_LHI  4'hF
`endif

module tb_alu_wide_sequencer;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic        req_wide;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        req_cin;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic        alu_cin;
    logic [3:0]  alu_op;
    logic [15:0] alu_c;
    logic        alu_cout;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_c;
    logic        rsp_cout;
`ifdef ALU_SEQ_FLAGS_EN
    logic        rsp_zero;
    logic        rsp_ovf;
`endif

    int n_cmp;
    int n_fail;

    alu_wide_sequencer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_wide  (req_wide),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_cin   (alu_cin),
        .alu_op    (alu_op),
        .alu_c     (alu_c),
        .alu_cout  (alu_cout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_c     (rsp_c),
        .rsp_cout  (rsp_cout)
`ifdef ALU_SEQ_FLAGS_EN
        ,
        .rsp_zero  (rsp_zero),
        .rsp_ovf   (rsp_ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 16-bit ALU; shifts move by one position and ignore b.
    always_comb begin : alu_model
        logic [16:0] s;
        s        = 17'h0;
        alu_c    = 16'h0000;
        alu_cout = 1'b0;
        case (alu_op)
            `OP_ID:   alu_c = alu_a;
            `OP_NAND: alu_c = ~(alu_a & alu_b);
            `OP_NOR:  alu_c = ~(alu_a | alu_b);
            `OP_XNOR: alu_c = ~(alu_a ^ alu_b);
            `OP_NOT:  alu_c = ~alu_a;
            `OP_AND:  alu_c = alu_a & alu_b;
            `OP_OR:   alu_c = alu_a | alu_b;
            `OP_XOR:  alu_c = alu_a ^ alu_b;
            `OP_ADD: begin
                s = {1'b0, alu_a} + {1'b0, alu_b} + {16'h0, alu_cin};
                alu_c = s[15:0];
                alu_cout = s[16];
            end
            `OP_SUB: begin
                s = {1'b0, alu_a} - {1'b0, alu_b} - {16'h0, alu_cin};
                alu_c = s[15:0];
                alu_cout = s[16];
            end
            `OP_RR:  alu_c = {alu_a[0], alu_a[15:1]};
            `OP_ARS: alu_c = {alu_a[15], alu_a[15:1]};
            `OP_LRS: alu_c = {1'b0, alu_a[15:1]};
            `OP_RL:  alu_c = {alu_a[14:0], alu_a[15]};
            `OP_ALS: alu_c = {alu_a[14:0], 1'b0};
            `OP_LHI: alu_c = {alu_b[7:0], 8'h00};
            default: alu_c = 16'h0000;
        endcase
    end

    // Reference: whole-word arithmetic on 32 bits (wide) or 16 bits (narrow).
    function automatic void ref_model(input logic [3:0] op, input logic wide,
                                      input logic [31:0] a, input logic [31:0] b,
                                      input logic cin, output logic [31:0] c,
                                      output logic cout, output logic zero,
                                      output logic ovf);
        logic        w;
        logic [32:0] t;
        logic [16:0] s;
        logic [15:0] a16;
        logic [15:0] b16;
        logic [15:0] c16;
        logic        sa;
        logic        sb;
        logic        sr;
        w    = wide && (op != `OP_LHI);
        a16  = a[15:0];
        b16  = b[15:0];
        c    = 32'h0;
        cout = 1'b0;
        if (w) begin
            case (op)
                `OP_ID:   c = a;
                `OP_NAND: c = ~(a & b);
                `OP_NOR:  c = ~(a | b);
                `OP_XNOR: c = ~(a ^ b);
                `OP_NOT:  c = ~a;
                `OP_AND:  c = a & b;
                `OP_OR:   c = a | b;
                `OP_XOR:  c = a ^ b;
                `OP_ADD: begin
                    t = {1'b0, a} + {1'b0, b} + {32'h0, cin};
                    c = t[31:0];
                    cout = t[32];
                end
                `OP_SUB: begin
                    t = {1'b0, a} - {1'b0, b} - {32'h0, cin};
                    c = t[31:0];
                    cout = t[32];
                end
                `OP_RR:  c = {a[0], a[31:1]};
                `OP_ARS: c = {a[31], a[31:1]};
                `OP_LRS: c = a >> 1;
                `OP_RL:  c = {a[30:0], a[31]};
                `OP_ALS: c = a << 1;
                default: c = 32'h0;
            endcase
        end else begin
            c16 = 16'h0;
            case (op)
                `OP_ID:   c16 = a16;
                `OP_NAND: c16 = ~(a16 & b16);
                `OP_NOR:  c16 = ~(a16 | b16);
                `OP_XNOR: c16 = ~(a16 ^ b16);
                `OP_NOT:  c16 = ~a16;
                `OP_AND:  c16 = a16 & b16;
                `OP_OR:   c16 = a16 | b16;
                `OP_XOR:  c16 = a16 ^ b16;
                `OP_ADD: begin
                    s = {1'b0, a16} + {1'b0, b16} + {16'h0, cin};
                    c16 = s[15:0];
                    cout = s[16];
                end
                `OP_SUB: begin
                    s = {1'b0, a16} - {1'b0, b16} - {16'h0, cin};
                    c16 = s[15:0];
                    cout = s[16];
                end
                `OP_RR:  c16 = {a16[0], a16[15:1]};
                `OP_ARS: c16 = {a16[15], a16[15:1]};
                `OP_LRS: c16 = a16 >> 1;
                `OP_RL:  c16 = {a16[14:0], a16[15]};
                `OP_ALS: c16 = a16 << 1;
                `OP_LHI: c16 = {b[7:0], 8'h00};
                default: c16 = 16'h0;
            endcase
            c = {16'h0, c16};
        end
        zero = w ? (c == 32'h0) : (c[15:0] == 16'h0);
        sa   = w ? a[31] : a[15];
        sb   = w ? b[31] : b[15];
        sr   = w ? c[31] : c[15];
        ovf  = 1'b0;
        if (op == `OP_ADD) ovf = (sa == sb) && (sr != sa);
        if (op == `OP_SUB) ovf = (sa != sb) && (sr != sa);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic        wide;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] exp_c;
        logic        exp_cout;
        string       name;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] op, input logic wide, input logic [31:0] a,
                                input logic [31:0] b, input logic cin, input logic [31:0] exp_c,
                                input logic exp_cout, input string name);
        vec_t v;
        v.op = op; v.wide = wide; v.a = a; v.b = b; v.cin = cin;
        v.exp_c = exp_c; v.exp_cout = exp_cout; v.name = name;
        return v;
    endfunction

    // Full request/response: accept, latency count, result check, handshake.
    task automatic run_op(input logic [3:0] op, input logic wide, input logic [31:0] a,
                          input logic [31:0] b, input logic cin, input logic [31:0] exp_c,
                          input logic exp_cout, input string name, input int ready_delay);
        int          guard;
        int          edges;
        logic        eff_wide;
        logic [31:0] mc;
        logic        mcout;
        logic        mz;
        logic        mo;
        ref_model(op, wide, a, b, cin, mc, mcout, mz, mo);
        eff_wide = wide && (op != `OP_LHI);
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_wide = wide;
        req_a = a; req_b = b; req_cin = cin;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            check({name, "_accept_timeout"}, 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        // Scramble the request inputs: they must only matter at accept.
        req_valid = 1'b0; req_op = 4'($urandom); req_wide = 1'($urandom);
        req_a = $urandom; req_b = $urandom; req_cin = 1'($urandom);
        edges = 1;
        while (!rsp_valid && edges < 20) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        // Edges counted from the accept edge inclusive.
        check({name, "_latency"}, 32'(edges), eff_wide ? 32'd3 : 32'd2);
        if (rsp_valid) begin
            check({name, "_c"}, rsp_c, exp_c);
            check({name, "_cout"}, 32'(rsp_cout), 32'(exp_cout));
`ifdef ALU_SEQ_FLAGS_EN
            check({name, "_zero"}, 32'(rsp_zero), 32'(mz));
            check({name, "_ovf"}, 32'(rsp_ovf), 32'(mo));
`endif
        end
        repeat (ready_delay) @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check({name, "_valid_after_hs"}, 32'(rsp_valid), 32'd0);
    endtask

    task automatic run_random(input string name);
        logic [3:0]  op;
        logic        wide;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] mc;
        logic        mcout;
        logic        mz;
        logic        mo;
        op   = 4'($urandom_range(0, 15));
        wide = 1'($urandom);
        a    = $urandom;
        b    = $urandom;
        cin  = 1'($urandom);
        if ($urandom_range(0, 3) == 0) a[15:0] = 16'hFFFF;
        ref_model(op, wide, a, b, cin, mc, mcout, mz, mo);
        run_op(op, wide, a, b, cin, mc, mcout, name, $urandom_range(0, 2));
    endtask

    vec_t vecs[$];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic seen_valid;
        n_cmp = 0;
        n_fail = 0;

        vecs.push_back(mk(`OP_ADD, 1'b0, 32'h0000FFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, "n_add_carry"));
        vecs.push_back(mk(`OP_ADD, 1'b1, 32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, "w_add_chain"));
        vecs.push_back(mk(`OP_SUB, 1'b1, 32'h00010000, 32'h00000001, 1'b0, 32'h0000FFFF, 1'b0, "w_sub_chain"));
        vecs.push_back(mk(`OP_SUB, 1'b1, 32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, "w_sub_borrow"));
        vecs.push_back(mk(`OP_RR,  1'b1, 32'h00000001, 32'h00000000, 1'b0, 32'h80000000, 1'b0, "w_rr"));
        vecs.push_back(mk(`OP_ARS, 1'b1, 32'h80000002, 32'h00000000, 1'b0, 32'hC0000001, 1'b0, "w_ars"));
        vecs.push_back(mk(`OP_LRS, 1'b1, 32'h00010000, 32'h00000000, 1'b0, 32'h00008000, 1'b0, "w_lrs"));
        vecs.push_back(mk(`OP_RL,  1'b1, 32'h80000000, 32'h00000000, 1'b0, 32'h00000001, 1'b0, "w_rl"));
        vecs.push_back(mk(`OP_ALS, 1'b1, 32'h00008000, 32'h00000000, 1'b0, 32'h00010000, 1'b0, "w_als"));
        vecs.push_back(mk(`OP_LHI, 1'b1, 32'h00000000, 32'h12345678, 1'b0, 32'h00007800, 1'b0, "w_lhi"));
        vecs.push_back(mk(`OP_ADD, 1'b1, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, "w_add_cin"));
        vecs.push_back(mk(`OP_SUB, 1'b0, 32'h00050003, 32'hABCD0005, 1'b0, 32'h0000FFFE, 1'b1, "n_sub_borrow"));
        vecs.push_back(mk(`OP_NAND, 1'b1, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'h0FFF0FFF, 1'b0, "w_nand"));
        vecs.push_back(mk(`OP_XOR, 1'b0, 32'h00001234, 32'h00001234, 1'b0, 32'h00000000, 1'b0, "n_xor_zero"));
        vecs.push_back(mk(`OP_ADD, 1'b1, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, "w_add_ovf"));

        reset_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_op = 4'h0; req_wide = 1'b0; req_a = 32'h0; req_b = 32'h0; req_cin = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_c", rsp_c, 32'h0);
        check("rst_rsp_cout", 32'(rsp_cout), 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        check("rst_alu_ab", {alu_a, alu_b}, 32'h0);
`ifdef ALU_SEQ_FLAGS_EN
        check("rst_flags", {30'h0, rsp_zero, rsp_ovf}, 32'h0);
`endif
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].wide, vecs[i].a, vecs[i].b, vecs[i].cin,
                   vecs[i].exp_c, vecs[i].exp_cout, vecs[i].name, 0);
        end

        // Wide ADD: watch both ALU passes and the carry chained into HI.
        @(negedge clk);
        req_valid = 1'b1; req_op = `OP_ADD; req_wide = 1'b1;
        req_a = 32'h0000FFFF; req_b = 32'h00000001; req_cin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("seq_lo_alu_op", 32'(alu_op), 32'(`OP_ADD));
        check("seq_lo_alu_a", 32'(alu_a), 32'h0000FFFF);
        check("seq_lo_alu_cin", 32'(alu_cin), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("seq_hi_alu_a", 32'(alu_a), 32'h0);
        check("seq_hi_alu_cin", 32'(alu_cin), 32'd1);
        check("seq_hi_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("seq_done_valid", 32'(rsp_valid), 32'd1);
        check("seq_done_c", rsp_c, 32'h00010000);
        check("seq_done_alu_op", 32'(alu_op), 32'd0);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;

        // Backpressure: response held while a competing request is offered.
        req_valid = 1'b1; req_op = `OP_SUB; req_wide = 1'b1;
        req_a = 32'h00010000; req_b = 32'h00000001; req_cin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_op = `OP_ADD; req_wide = 1'b0; req_a = 32'h1; req_b = 32'h1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_c", rsp_c, 32'h0000FFFF);
            check("bp_cout", 32'(rsp_cout), 32'd0);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("bp_idle_ready", 32'(req_ready), 32'd1);
        seen_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid || !req_ready) seen_valid = 1'b1;
        end
        check("bp_not_captured", 32'(seen_valid), 32'd0);

        // Reset pulse while the HI pass is on the ALU.
        req_valid = 1'b1; req_op = `OP_ADD; req_wide = 1'b1;
        req_a = 32'h12345678; req_b = 32'h11111111; req_cin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_hi_alu_a", 32'(alu_a), 32'h1234);
        #1 reset_n = 1'b0;
        #1;
        check("rstmid_req_ready", 32'(req_ready), 32'd1);
        check("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rstmid_rsp_c", rsp_c, 32'h0);
        check("rstmid_rsp_cout", 32'(rsp_cout), 32'd0);
        check("rstmid_alu", {alu_op, alu_cin, 11'h0, alu_a}, 32'h0);
`ifdef ALU_SEQ_FLAGS_EN
        check("rstmid_flags", {30'h0, rsp_zero, rsp_ovf}, 32'h0);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        seen_valid = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid) seen_valid = 1'b1;
        end
        check("rstmid_no_rsp", 32'(seen_valid), 32'd0);

        for (int i = 0; i < 250; i++) begin
            run_random("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
